// File: rtl/chip8_display_engine.sv
// chip8_display_engine: queues sprite-row draw strobes from the CPU and XORs
// each row into a 64x32 1bpp framebuffer (256 x 8 RAM), reporting pixel
// erasure as a one-cycle collision pulse. A second read port serves scanout.
module chip8_display_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_BYTES   = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       draw,
    input  logic [5:0] x,
    input  logic [4:0] y,
    input  logic [7:0] sprite_data,
    input  logic [3:0] draw_row_index,
    input  logic       clear_req,
    input  logic [7:0] vid_addr,
    output logic [7:0] vid_data,
    output logic       collision,
    output logic       busy,
    output logic       overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WR0, S_WR1, S_DONE, S_CLEAR} state_t;

    typedef struct packed {
        logic [5:0] px;
        logic [4:0] py;
        logic [7:0] pdata;
        logic [3:0] pidx;
    } draw_req_t;

    // Draw-request queue
    draw_req_t         fifo_mem [FIFO_DEPTH];
    draw_req_t         head;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              fifo_empty, fifo_full, push, pop;
    logic              overflow_q, overflow_d;

    // Engine state
    state_t            state_q, state_d;
    logic [4:0]        ry_q, ry_d;
    logic [2:0]        b0_q, b0_d, b1_q, b1_d;
    logic [7:0]        m0_q, m0_d, m1_q, m1_d;
    logic              hit_q, hit_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              clear_pend_q, clear_pend_d;
    logic              collision_q, collision_d;

    // Geometry of the row at the queue head
    logic [4:0]        ry_w;
    logic [15:0]       sh_w;

    // Framebuffer
    logic [7:0]        fb_mem [FB_BYTES];
    logic [7:0]        ram_raddr, ram_waddr, ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata_q;
    logic [7:0]        vid_data_q;

    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));

    // Queue bookkeeping: a clear flushes first, then a same-cycle draw is enqueued
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        if (clear_req) begin
            rd_ptr_d = wr_ptr_q;
            push     = draw;
            count_d  = (PW+1)'(draw);
        end else begin
            push = draw && (!fifo_full || pop);
            if (draw && fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    // Queue storage; entries need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{px: x, py: y, pdata: sprite_data, pidx: draw_row_index};
        end
    end

    // Row geometry: m0 is the upper byte of the shifted row, m1 the spill into the next byte
    always_comb begin
        ry_w = head.py + {1'b0, head.pidx};
        sh_w = {head.pdata, 8'h00} >> head.px[2:0];
    end

    // Engine next-state: read-modify-write of one or two bytes per row, or clear sweep
    always_comb begin
        state_d      = state_q;
        ry_d         = ry_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        m0_d         = m0_q;
        m1_d         = m1_q;
        hit_d        = hit_q;
        cnt_d        = cnt_q;
        clear_pend_d = clear_pend_q | clear_req;
        collision_d  = 1'b0;
        pop          = 1'b0;
        ram_raddr    = {ry_q, b1_q};
        ram_we       = 1'b0;
        ram_waddr    = {ry_q, b0_q};
        ram_wdata    = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (clear_pend_q || clear_req) begin
                    state_d      = S_CLEAR;
                    cnt_d        = 8'h00;
                    clear_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    ry_d      = ry_w;
                    b0_d      = head.px[5:3];
                    b1_d      = head.px[5:3] + 3'd1;
                    m0_d      = sh_w[15:8];
                    m1_d      = sh_w[7:0];
                    ram_raddr = {ry_w, head.px[5:3]};
                    state_d   = S_WR0;
                end
            end
            S_WR0: begin
                ram_we    = 1'b1;
                ram_waddr = {ry_q, b0_q};
                ram_wdata = ram_rdata_q ^ m0_q;
                hit_d     = hit_q | (|(ram_rdata_q & m0_q));
                ram_raddr = {ry_q, b1_q};
                state_d   = (m1_q != 8'h00) ? S_WR1 : S_DONE;
            end
            S_WR1: begin
                ram_we    = 1'b1;
                ram_waddr = {ry_q, b1_q};
                ram_wdata = ram_rdata_q ^ m1_q;
                hit_d     = hit_q | (|(ram_rdata_q & m1_q));
                state_d   = S_DONE;
            end
            S_DONE: begin
                collision_d = hit_q;
                hit_d       = 1'b0;
                state_d     = S_IDLE;
            end
            S_CLEAR: begin
                ram_we       = 1'b1;
                ram_waddr    = cnt_q;
                ram_wdata    = 8'h00;
                clear_pend_d = 1'b0;
                if (clear_req) begin
                    cnt_d = 8'h00;
                end else if (cnt_q == 8'(FB_BYTES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Engine and queue registers; reset forces a full framebuffer clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_CLEAR;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            ry_q         <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            m0_q         <= '0;
            m1_q         <= '0;
            hit_q        <= 1'b0;
            cnt_q        <= '0;
            clear_pend_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            ry_q         <= ry_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            m0_q         <= m0_d;
            m1_q         <= m1_d;
            hit_q        <= hit_d;
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            collision_q  <= collision_d;
        end
    end

    // Framebuffer engine port: one write and one registered read per cycle
    always_ff @(posedge clk) begin
        if (ram_we) begin
            fb_mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata_q <= fb_mem[ram_raddr];
    end

    // Scanout port: registered read, returns pre-write data on address clash
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_data_q <= 8'h00;
        end else begin
            vid_data_q <= fb_mem[vid_addr];
        end
    end

    assign vid_data  = vid_data_q;
    assign collision = collision_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty || clear_pend_q;

endmodule

// File: tb/tb_chip8_display_engine.sv
// Directed bench for chip8_display_engine: reset clear, XOR/collision,
// wrap geometry, CPU-cadence streaming, overflow, clear flush, mid-row reset.
module tb_chip8_display_engine;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       draw;
    logic [5:0] x;
    logic [4:0] y;
    logic [7:0] sprite_data;
    logic [3:0] draw_row_index;
    logic       clear_req;
    logic [7:0] vid_addr;
    logic [7:0] vid_data;
    logic       collision;
    logic       busy;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int coll_count = 0;
    logic [7:0] exp_fb [256];

    chip8_display_engine #(.FIFO_DEPTH(4), .FB_BYTES(256)) dut (
        .clk(clk), .reset_n(reset_n), .draw(draw), .x(x), .y(y),
        .sprite_data(sprite_data), .draw_row_index(draw_row_index),
        .clear_req(clear_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .collision(collision), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (collision === 1'b1) coll_count++;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_draw(input logic [5:0] dx, input logic [4:0] dy,
                           input logic [7:0] dd, input logic [3:0] di);
        x = dx; y = dy; sprite_data = dd; draw_row_index = di; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] a, output logic [7:0] d);
        vid_addr = a;
        @(negedge clk);
        d = vid_data;
    endtask

    task automatic watch(input int cycles, output int pulses, output int first);
        pulses = 0; first = -1;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (collision === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output int waited);
        waited = 0;
        while (busy !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic scan_fb(output int bad, output int first_addr);
        logic [7:0] d;
        bad = 0; first_addr = -1;
        for (int a = 0; a < 256; a++) begin
            read_byte(8'(a), d);
            if (d !== exp_fb[a]) begin
                bad++;
                if (first_addr < 0) first_addr = a;
            end
        end
    endtask

    task automatic test_reset;
        int w, bad, fa;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %b expected 0", collision); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_tests++; if (vid_data !== 8'h00) begin n_fail++; $display("FAIL reset_vid_data: got %h expected 00", vid_data); end
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_mid: got %b expected 1", busy); end
        wait_idle(200, w);
        n_tests++; if (busy !== 1'b0 || (200 + w) != 256) begin
            n_fail++; $display("FAIL clear_duration: busy %b after %0d cycles expected 0 after 256", busy, 200 + w);
        end
        for (int a = 0; a < 256; a++) exp_fb[a] = 8'h00;
        scan_fb(bad, fa);
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL reset_fb_zero: %0d bad bytes, first at %0d expected 0 bad", bad, fa); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_xor_collision;
        int p, f;
        logic [7:0] d;
        do_draw(6'd0, 5'd0, 8'hF0, 4'd0);
        watch(8, p, f);
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL draw1_collision: got %0d pulses expected 0", p); end
        read_byte(8'h00, d);
        n_tests++; if (d !== 8'hF0) begin n_fail++; $display("FAIL draw1_byte: got %h expected f0", d); end
        do_draw(6'd0, 5'd0, 8'hF0, 4'd0);
        watch(8, p, f);
        n_tests++; if (p != 1 || f != 3) begin n_fail++; $display("FAIL draw2_collision: got %0d pulses at %0d expected 1 at 3", p, f); end
        read_byte(8'h00, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL draw2_byte: got %h expected 00", d); end
        $display("[TB] test_xor_collision done");
    endtask

    task automatic test_wrap;
        int p, f;
        logic [7:0] d;
        do_draw(6'd60, 5'd31, 8'hFF, 4'd1);
        watch(8, p, f);
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL wrap_collision: got %0d pulses expected 0", p); end
        read_byte(8'h07, d);
        n_tests++; if (d !== 8'h0F) begin n_fail++; $display("FAIL wrap_byte7: got %h expected 0f", d); end
        read_byte(8'h00, d);
        n_tests++; if (d !== 8'hF0) begin n_fail++; $display("FAIL wrap_byte0: got %h expected f0", d); end
        do_draw(6'd60, 5'd31, 8'hFF, 4'd1);
        watch(8, p, f);
        n_tests++; if (p != 1 || f != 4) begin n_fail++; $display("FAIL wrap_redraw_collision: got %0d pulses at %0d expected 1 at 4", p, f); end
        read_byte(8'h07, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_redraw_byte7: got %h expected 00", d); end
        read_byte(8'h00, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_redraw_byte0: got %h expected 00", d); end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_cpu_cadence;
        int c0, w;
        logic [7:0] d, sd, e0, e1;
        logic [4:0] ry;
        for (int pass = 0; pass < 2; pass++) begin
            c0 = coll_count;
            for (int i = 0; i < 15; i++) begin
                do_draw(6'd4, 5'd2, 8'hA5 ^ 8'(i), 4'(i));
                repeat (2) @(negedge clk);
            end
            wait_idle(200, w);
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cadence_idle pass %0d: busy %b expected 0", pass, busy); end
            repeat (3) @(negedge clk);
            n_tests++; if ((coll_count - c0) != (pass == 0 ? 0 : 15)) begin
                n_fail++; $display("FAIL cadence_pulses pass %0d: got %0d expected %0d", pass, coll_count - c0, pass == 0 ? 0 : 15);
            end
            n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL cadence_overflow pass %0d: got %b expected 0", pass, overflow); end
            for (int i = 0; i < 15; i++) begin
                ry = 5'(2 + i);
                sd = 8'hA5 ^ 8'(i);
                e0 = (pass == 0) ? {4'h0, sd[7:4]} : 8'h00;
                e1 = (pass == 0) ? {sd[3:0], 4'h0} : 8'h00;
                read_byte({ry, 3'd0}, d);
                n_tests++; if (d !== e0) begin n_fail++; $display("FAIL cadence_row%0d_b0 pass %0d: got %h expected %h", i, pass, d, e0); end
                read_byte({ry, 3'd1}, d);
                n_tests++; if (d !== e1) begin n_fail++; $display("FAIL cadence_row%0d_b1 pass %0d: got %h expected %h", i, pass, d, e1); end
            end
        end
        $display("[TB] test_cpu_cadence done");
    endtask

    task automatic test_overflow;
        int w;
        for (int i = 0; i < 10; i++) begin
            do_draw(6'd0, 5'd20, 8'h01, 4'(i));
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        wait_idle(200, w);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overflow_idle: busy %b expected 0", busy); end
        repeat (3) @(negedge clk);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_clear_flush;
        int c0, w, bad, fa;
        do_draw(6'd12, 5'd5, 8'hFF, 4'd0);
        wait_idle(50, w);
        repeat (3) @(negedge clk);
        c0 = coll_count;
        // A re-drawn (collides, in flight), then B/C/D queued behind it
        x = 6'd12; y = 5'd5; sprite_data = 8'hFF; draw_row_index = 4'd0; draw = 1'b1;
        @(negedge clk);
        x = 6'd0; y = 5'd20; sprite_data = 8'h81; draw_row_index = 4'd0;
        @(negedge clk);
        draw_row_index = 4'd1;
        @(negedge clk);
        draw_row_index = 4'd2;
        @(negedge clk);
        draw = 1'b0; clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy: got %b expected 1", busy); end
        do_draw(6'd0, 5'd10, 8'h3C, 4'd0);
        wait_idle(400, w);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_idle: busy %b expected 0", busy); end
        repeat (3) @(negedge clk);
        n_tests++; if ((coll_count - c0) != 1) begin n_fail++; $display("FAIL clear_inflight_pulse: got %0d expected 1", coll_count - c0); end
        for (int a = 0; a < 256; a++) exp_fb[a] = 8'h00;
        exp_fb[{5'd10, 3'd0}] = 8'h3C;
        scan_fb(bad, fa);
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL clear_fb_image: %0d bad bytes, first at %0d expected 0 bad", bad, fa); end
        $display("[TB] test_clear_flush done");
    endtask

    task automatic test_reset_mid_row;
        int c0, w, bad, fa;
        c0 = coll_count;
        do_draw(6'd4, 5'd10, 8'hFF, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL midreset_collision: got %b expected 0", collision); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: got %b expected 1", busy); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_overflow: got %b expected 0", overflow); end
        n_tests++; if (vid_data !== 8'h00) begin n_fail++; $display("FAIL midreset_vid_data: got %h expected 00", vid_data); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++; if ((coll_count - c0) != 0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d expected 0", coll_count - c0); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_clearing: busy %b expected 1", busy); end
        wait_idle(300, w);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: busy %b expected 0", busy); end
        for (int a = 0; a < 256; a++) exp_fb[a] = 8'h00;
        scan_fb(bad, fa);
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midreset_fb_zero: %0d bad bytes, first at %0d expected 0 bad", bad, fa); end
        $display("[TB] test_reset_mid_row done");
    endtask

    initial begin
        reset_n = 1'b0; draw = 1'b0; x = '0; y = '0; sprite_data = '0;
        draw_row_index = '0; clear_req = 1'b0; vid_addr = '0;
        @(negedge clk);
        test_reset();
        test_xor_collision();
        test_wrap();
        test_cpu_cadence();
        test_overflow();
        test_clear_flush();
        test_reset_mid_row();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
